minicpu_fetch: RTL

Instruction-fetch stage that sits directly upstream of the miniCPU decode/execute datapath. It generates the fetch PC and issues reads to a synchronous instruction SRAM with one-cycle read latency. Returned words are buffered in a small instruction queue and handed to decode with a valid/ready handshake. A taken branch from downstream redirects fetch and flushes everything fetched down the old path.

---
 rtl/minicpu_fetch.sv | 70 +++++++
 1 files changed

// File: rtl/minicpu_fetch.sv
// minicpu_fetch: PC generation, one-cycle-latency instruction SRAM reads, and a small queue feeding decode.
module minicpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  input  logic        ds_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] fpc, req_pc;
  logic req_valid, pop, push;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [AW+1:0] occ;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  assign pop = fs_valid & ds_ready;
  assign push = req_valid & ~br_taken;
  // words already held or in flight once this cycle's pop retires
  assign occ = {1'b0, count} + (AW+2)'(req_valid) - (AW+2)'(pop);
  assign inst_sram_en = ~reset & (br_taken | (occ < (AW+2)'(DEPTH)));
  assign inst_sram_addr = br_taken ? br_target : fpc;
  assign inst_sram_we = 1'b0;
  assign inst_sram_wdata = 32'h0;
  assign fs_valid = count != '0;
  assign fs_pc = q_pc[rptr];
  assign fs_inst = q_inst[rptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc <= RESET_PC;
      req_pc <= 32'h0;
      req_valid <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      req_valid <= inst_sram_en;
      if (inst_sram_en) begin
        fpc <= inst_sram_addr + 32'd4;
        req_pc <= inst_sram_addr;
      end
      if (br_taken) begin
        count <= '0;
        rptr <= wptr;
      end else begin
        wptr <= wptr + AW'(push);
        rptr <= rptr + AW'(pop);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wptr] <= req_pc;
      q_inst[wptr] <= inst_sram_rdata;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> (count < (AW+1)'(DEPTH)));
endmodule
